// File: rtl/hash_job_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : hash_job_ctrl
//  Purpose  : Host-side initiator/consumer for the bitcoin_hash memory
//             protocol. Streams a MSG_WORDS-word block header into shared
//             memory, pulses the hasher's start, waits for done, reads back
//             NUM_NONCES H0 result words and reports the winning nonce
//             against a 32-bit target (hit when H0 < target, unsigned).
//
//  Ports    : clk, reset          clock, asynchronous active-high reset
//             job_valid/ready/data header word stream (valid/ready handshake)
//             target              threshold, latched on the first header word
//             message_addr        header base address (also used by hasher)
//             output_addr         result base address (also used by hasher)
//             hash_start          one-cycle start pulse to the hasher
//             hash_done           hasher done level, only looked at in WAIT
//             mem_own             1 = this block drives memory, 0 = hasher
//             mem_we/addr/write_data/read_data   shared memory port
//             result_valid        one-cycle pulse when a job's result is ready
//             found/nonce/best_hash  held result of the last job
//
//  Options  : HASH_JOB_MIN_SCAN_EN  defined   -> minimum-search policy
//                                   undefined -> first-hit policy (default)
//
//  Revision : 1.0  initial release
// ============================================================================
module hash_job_ctrl #(
  parameter int  NUM_NONCES = 16,
  parameter int  MSG_WORDS  = 19,
  localparam int IDX_W      = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [31:0]      job_data,
  input  logic [31:0]      target,
  input  logic [15:0]      message_addr,
  input  logic [15:0]      output_addr,
  output logic             hash_start,
  input  logic             hash_done,
  output logic             mem_own,
  output logic             mem_we,
  output logic [15:0]      mem_addr,
  output logic [31:0]      mem_write_data,
  input  logic [31:0]      mem_read_data,
  output logic             result_valid,
  output logic             found,
  output logic [IDX_W-1:0] nonce,
  output logic [31:0]      best_hash
);

  localparam int WC_W = (MSG_WORDS > 1) ? $clog2(MSG_WORDS) : 1;
  localparam int RC_W = $clog2(NUM_NONCES + 2);

  localparam logic [WC_W-1:0] WC_LAST       = WC_W'(MSG_WORDS - 1);
  localparam logic [RC_W-1:0] RC_ONE        = RC_W'(1);
  localparam logic [RC_W-1:0] RC_ISSUE_END  = RC_W'(NUM_NONCES - 1);
  localparam logic [RC_W-1:0] RC_SAMPLE_END = RC_W'(NUM_NONCES);
  localparam logic [RC_W-1:0] RC_LAST       = RC_W'(NUM_NONCES + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_READ   = 3'd4,
    S_REPORT = 3'd5
  } state_t;

  state_t state, state_nxt;

  // Registered outputs: next values
  logic             job_ready_nxt;
  logic             hash_start_nxt;
  logic             mem_own_nxt;
  logic             mem_we_nxt;
  logic [15:0]      mem_addr_nxt;
  logic [31:0]      mem_write_data_nxt;
  logic             result_valid_nxt;
  logic             found_nxt;
  logic [IDX_W-1:0] nonce_nxt;
  logic [31:0]      best_hash_nxt;

  // Internal state
  logic [31:0]      target_q, target_q_nxt;
  logic [WC_W-1:0]  wc, wc_nxt;
  logic [RC_W-1:0]  rc, rc_nxt;
  logic [31:0]      rd_data, rd_data_nxt;
  logic [IDX_W-1:0] rd_idx, rd_idx_nxt;
  logic             rd_vld, rd_vld_nxt;
  logic             win_found, win_found_nxt;
  logic [IDX_W-1:0] win_idx, win_idx_nxt;
  logic [31:0]      win_hash, win_hash_nxt;

  // Winner after folding in the currently staged result word
  logic             upd_found;
  logic [IDX_W-1:0] upd_idx;
  logic [31:0]      upd_hash;

  logic accept;
  assign accept = job_valid && job_ready;

  // --------------------------------------------------------------------------
  // Winner selection. Winner registers start at (0, 0, FFFFFFFF) on entry to
  // READ, so with strict comparisons an all-FFFFFFFF scan leaves index 0 and
  // FFFFFFFF in place for both policies, and ties keep the lower index.
  // --------------------------------------------------------------------------
  always_comb begin
    upd_found = win_found;
    upd_idx   = win_idx;
    upd_hash  = win_hash;
    if (rd_vld) begin
`ifdef HASH_JOB_MIN_SCAN_EN
      if (rd_data < win_hash) begin
        upd_idx  = rd_idx;
        upd_hash = rd_data;
      end
      upd_found = (upd_hash < target_q);
`else
      if (!win_found && (rd_data < target_q)) begin
        upd_found = 1'b1;
        upd_idx   = rd_idx;
        upd_hash  = rd_data;
      end
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt          = state;
    hash_start_nxt     = 1'b0;
    mem_own_nxt        = mem_own;
    mem_we_nxt         = 1'b0;
    mem_addr_nxt       = mem_addr;
    mem_write_data_nxt = mem_write_data;
    result_valid_nxt   = 1'b0;
    found_nxt          = found;
    nonce_nxt          = nonce;
    best_hash_nxt      = best_hash;
    target_q_nxt       = target_q;
    wc_nxt             = wc;
    rc_nxt             = rc;
    rd_data_nxt        = rd_data;
    rd_idx_nxt         = rd_idx;
    rd_vld_nxt         = 1'b0;
    win_found_nxt      = upd_found;
    win_idx_nxt        = upd_idx;
    win_hash_nxt       = upd_hash;

    case (state)
      // IDLE and LOAD share the write path; wc is 0 in IDLE, so the first
      // word lands at message_addr and the target is captured with it.
      S_IDLE, S_LOAD: begin
        mem_own_nxt = 1'b1;
        if (accept) begin
          mem_we_nxt         = 1'b1;
          mem_addr_nxt       = message_addr + 16'(wc);
          mem_write_data_nxt = job_data;
          if (state == S_IDLE) begin
            target_q_nxt = target;
          end
          if (wc == WC_LAST) begin
            wc_nxt    = '0;
            state_nxt = S_START;
          end else begin
            wc_nxt    = wc + 1'b1;
            state_nxt = S_LOAD;
          end
        end
      end

      S_START: begin
        mem_own_nxt    = 1'b0;
        hash_start_nxt = 1'b1;
        state_nxt      = S_WAIT;
      end

      S_WAIT: begin
        mem_own_nxt = 1'b0;
        if (hash_done) begin
          mem_own_nxt   = 1'b1;
          mem_addr_nxt  = output_addr;
          rc_nxt        = '0;
          win_found_nxt = 1'b0;
          win_idx_nxt   = '0;
          win_hash_nxt  = 32'hFFFF_FFFF;
          state_nxt     = S_READ;
        end
      end

      // rc counts READ cycles 0..NUM_NONCES+1. Address i+1 is issued at the
      // end of cycle i, the word for index i is captured at the end of cycle
      // i+1 (two edges after its address) and folded into the winner one
      // cycle later, so the last index is folded at the end of cycle
      // NUM_NONCES+1 and the report values come straight from upd_*.
      S_READ: begin
        rc_nxt = rc + RC_ONE;
        if (rc < RC_ISSUE_END) begin
          mem_addr_nxt = mem_addr + 16'd1;
        end
        if ((rc >= RC_ONE) && (rc <= RC_SAMPLE_END)) begin
          rd_data_nxt = mem_read_data;
          rd_idx_nxt  = IDX_W'(rc - RC_ONE);
          rd_vld_nxt  = 1'b1;
        end
        if (rc == RC_LAST) begin
          result_valid_nxt = 1'b1;
          found_nxt        = upd_found;
          nonce_nxt        = upd_idx;
          best_hash_nxt    = upd_hash;
          state_nxt        = S_REPORT;
        end
      end

      S_REPORT: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt   = S_IDLE;
        mem_own_nxt = 1'b1;
      end
    endcase

    job_ready_nxt = (state_nxt == S_IDLE) || (state_nxt == S_LOAD);
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      job_ready      <= 1'b0;
      hash_start     <= 1'b0;
      mem_own        <= 1'b1;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      result_valid   <= 1'b0;
      found          <= 1'b0;
      nonce          <= '0;
      best_hash      <= 32'hFFFF_FFFF;
      target_q       <= '0;
      wc             <= '0;
      rc             <= '0;
      rd_data        <= '0;
      rd_idx         <= '0;
      rd_vld         <= 1'b0;
      win_found      <= 1'b0;
      win_idx        <= '0;
      win_hash       <= 32'hFFFF_FFFF;
    end else begin
      state          <= state_nxt;
      job_ready      <= job_ready_nxt;
      hash_start     <= hash_start_nxt;
      mem_own        <= mem_own_nxt;
      mem_we         <= mem_we_nxt;
      mem_addr       <= mem_addr_nxt;
      mem_write_data <= mem_write_data_nxt;
      result_valid   <= result_valid_nxt;
      found          <= found_nxt;
      nonce          <= nonce_nxt;
      best_hash      <= best_hash_nxt;
      target_q       <= target_q_nxt;
      wc             <= wc_nxt;
      rc             <= rc_nxt;
      rd_data        <= rd_data_nxt;
      rd_idx         <= rd_idx_nxt;
      rd_vld         <= rd_vld_nxt;
      win_found      <= win_found_nxt;
      win_idx        <= win_idx_nxt;
      win_hash       <= win_hash_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hash_job_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_hash_job_ctrl
//  Purpose  : Self-checking bench for hash_job_ctrl. Models shared memory
//             (registered read) and a behavioural hasher, streams headers,
//             and checks outputs every cycle against a result model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hash_job_ctrl;

  localparam int NUM   = 16;
  localparam int MSG   = 19;
  localparam int IDX_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             job_valid, job_ready;
  logic [31:0]      job_data, target;
  logic [15:0]      message_addr, output_addr;
  logic             hash_start, hash_done;
  logic             mem_own, mem_we;
  logic [15:0]      mem_addr;
  logic [31:0]      mem_write_data, mem_read_data;
  logic             result_valid, found;
  logic [IDX_W-1:0] nonce;
  logic [31:0]      best_hash;

  always #5 clk = ~clk;

  hash_job_ctrl #(.NUM_NONCES(NUM), .MSG_WORDS(MSG)) dut (
    .clk(clk), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready), .job_data(job_data),
    .target(target), .message_addr(message_addr), .output_addr(output_addr),
    .hash_start(hash_start), .hash_done(hash_done),
    .mem_own(mem_own), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .result_valid(result_valid), .found(found), .nonce(nonce),
    .best_hash(best_hash)
  );

  // Shared memory: the hasher port (h_*) stands in for the hasher's writes.
  logic [31:0] mem [0:65535];
  logic [31:0] rd_q;
  logic        h_we;
  logic [15:0] h_addr;
  logic [31:0] h_data;
  always @(posedge clk) begin
    if (h_we) mem[h_addr] <= h_data;
    else if (mem_we && mem_own) mem[mem_addr] <= mem_write_data;
    rd_q <= mem[mem_addr];
  end
  assign mem_read_data = rd_q;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Expected timing windows (cycle numbers) and held-result model
  int exp_rv = -1, exp_hs = -1, own_lo = 1, own_hi = 0;
  int wr_count = 0, hs_count = 0;
  logic             m_found = 1'b0;
  logic [IDX_W-1:0] m_nonce = '0;
  logic [31:0]      m_hash  = 32'hFFFF_FFFF;
  logic             job_f;
  logic [IDX_W-1:0] job_n;
  logic [31:0]      job_h;

  logic [31:0] hdr [MSG];
  logic [31:0] res [NUM];
  logic [31:0] tgt;
  logic [15:0] maddr;

  // Result rule straight from the policy description
  task automatic model(output logic f, output logic [IDX_W-1:0] n, output logic [31:0] h);
`ifdef HASH_JOB_MIN_SCAN_EN
    h = res[0]; n = '0;
    for (int i = 1; i < NUM; i++)
      if (res[i] < h) begin h = res[i]; n = IDX_W'(i); end
    f = (h < tgt);
`else
    f = 1'b0; n = '0; h = 32'hFFFF_FFFF;
    for (int i = 0; i < NUM; i++)
      if (res[i] < tgt) begin f = 1'b1; n = IDX_W'(i); h = res[i]; break; end
`endif
  endtask

  // Per-cycle compare process
  always @(negedge clk) begin
    if (reset) begin
      m_found = 1'b0; m_nonce = '0; m_hash = 32'hFFFF_FFFF;
    end else begin
      if (cyc == exp_rv) begin
        m_found = job_f; m_nonce = job_n; m_hash = job_h;
      end
      chk("result_valid", result_valid, cyc == exp_rv);
      chk("found", found, m_found);
      chk("nonce", nonce, m_nonce);
      chk("best_hash", best_hash, m_hash);
      chk("mem_own", mem_own, !(cyc >= own_lo && cyc <= own_hi));
      chk("hash_start", hash_start, cyc == exp_hs);
      if (mem_we) begin
        wr_count++;
        chk("we_while_owned", mem_own, 1);
      end
      if (hash_start) hs_count++;
    end
  end

  task automatic check_reset_vals();
    chk("rst_job_ready", job_ready, 0);
    chk("rst_hash_start", hash_start, 0);
    chk("rst_mem_own", mem_own, 1);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_write_data, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_found", found, 0);
    chk("rst_nonce", nonce, 0);
    chk("rst_best_hash", best_hash, 32'hFFFF_FFFF);
  endtask

  // Called just after a negedge: asynchronous reset mid-cycle
  task automatic do_reset();
    #2 reset = 1'b1;
    exp_rv = -1; exp_hs = -1; own_lo = 1; own_hi = 0;
    #1 check_reset_vals();
    @(negedge clk); @(negedge clk);
    #2 reset = 1'b0;
    hash_done = 1'b0; job_valid = 1'b0;
  endtask

  // bub: 0 valid held, 1 alternate 1/0, 2 random
  // dly: -1 done high before the job, else cycles after start pulse
  // abort: 0 none, 1 reset in WAIT, 2 reset in READ
  task automatic run_job(input int bub, input int dly, input int abort);
    int k, guard, c_acc, a_cyc, wb, hb, bad;
    logic v;
    logic [15:0] oaddr;
    oaddr = maddr + 16'h8000;
    for (int i = 0; i < NUM; i++) begin
      @(negedge clk); h_we = 1'b1; h_addr = oaddr + 16'(i); h_data = res[i];
    end
    for (int i = 0; i < MSG; i++) begin
      @(negedge clk); h_we = 1'b1; h_addr = maddr + 16'(i); h_data = ~hdr[i];
    end
    @(negedge clk); h_we = 1'b0;
    model(job_f, job_n, job_h);
    message_addr = maddr; output_addr = oaddr;
    if (dly < 0) hash_done = 1'b1;
    wb = wr_count; hb = hs_count;
    k = 0; guard = 0; c_acc = 0;
    while (k < MSG && guard < 400) begin
      @(negedge clk);
      case (bub)
        0: v = 1'b1;
        1: v = (guard % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      job_valid = v; job_data = hdr[k];
      target = (k == 0) ? tgt : $urandom;
      if (v && job_ready) begin c_acc = cyc; k++; end
      guard++;
    end
    chk("stream_words", k, MSG);
    if (k < MSG) begin
      job_valid = 1'b0;
      do_reset();
      return;
    end
    exp_hs = c_acc + 2;
    own_lo = c_acc + 2;
    a_cyc  = (dly < 0) ? c_acc + 2 : c_acc + 2 + dly;
    if (abort == 1) begin own_hi = 32'h4000_0000; exp_rv = -1; end
    else begin own_hi = a_cyc; exp_rv = a_cyc + NUM + 3; end
    @(negedge clk); job_valid = 1'b0; job_data = $urandom;
    if (abort == 1) begin
      while (cyc < c_acc + 4) @(negedge clk);
      do_reset();
      return;
    end
    while (cyc < a_cyc) @(negedge clk);
    hash_done = 1'b1;
    while (cyc < a_cyc + 1) @(negedge clk);
    hash_done = 1'b0;
    if (abort == 2) begin
      while (cyc < a_cyc + 5) @(negedge clk);
      do_reset();
      return;
    end
    while (cyc < exp_rv + 2) @(negedge clk);
    chk("write_count", wr_count - wb, MSG);
    chk("start_pulses", hs_count - hb, 1);
    bad = 0;
    for (int i = 0; i < MSG; i++)
      if (mem[maddr + 16'(i)] !== hdr[i]) bad++;
    chk("header_mem", bad, 0);
    chk("job_found", found, job_f);
    chk("job_nonce", nonce, job_n);
    chk("job_best", best_hash, job_h);
  endtask

  task automatic gen_random();
    maddr = 16'($urandom);
    for (int i = 0; i < MSG; i++) hdr[i] = $urandom;
    for (int i = 0; i < NUM; i++) begin
      case ($urandom_range(0, 3))
        0: res[i] = $urandom_range(0, 32'h7FFF);
        1: res[i] = (i > 0) ? res[$urandom_range(0, i - 1)] : 32'hFFFF_FFFF;
        2: res[i] = 32'hFFFF_FFFF;
        default: res[i] = $urandom;
      endcase
    end
    case ($urandom_range(0, 4))
      0: tgt = 32'h0;
      1: tgt = 32'hFFFF_FFFF;
      2: tgt = 32'h0000_4000;
      default: tgt = $urandom;
    endcase
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    job_valid = 0; job_data = 0; target = 0; message_addr = 0; output_addr = 0;
    hash_done = 0; h_we = 0; h_addr = 0; h_data = 0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    #2 reset = 1'b0;

    // Single hit, header 0x100.. at address 0, valid held
    maddr = 16'h0000;
    for (int i = 0; i < MSG; i++) hdr[i] = 32'h100 + i;
    for (int i = 0; i < NUM; i++) res[i] = 32'h8000_0000;
    res[3] = 32'h10; tgt = 32'h1000;
    run_job(0, 2, 0);
    chk("lit1_found", found, 1);
    chk("lit1_nonce", nonce, 3);
    chk("lit1_best", best_hash, 32'h10);

    // Two hits, bubbles on the stream
    for (int i = 0; i < NUM; i++) res[i] = 32'hFFFF_FFFF;
    res[2] = 32'h500; res[9] = 32'h100; tgt = 32'h1000;
    run_job(1, 0, 0);
    chk("lit2_found", found, 1);
`ifdef HASH_JOB_MIN_SCAN_EN
    chk("lit2_nonce", nonce, 9);
    chk("lit2_best", best_hash, 32'h100);
`else
    chk("lit2_nonce", nonce, 2);
    chk("lit2_best", best_hash, 32'h500);
`endif

    // Reset while waiting for the hasher (a hit is currently held)
    gen_random();
    run_job(2, 0, 1);

    // No hit at the top of the range; done already high when WAIT is entered
    maddr = 16'h1234;
    for (int i = 0; i < MSG; i++) hdr[i] = $urandom;
    for (int i = 0; i < NUM; i++) res[i] = 32'hFFFF_FFFF;
    tgt = 32'hFFFF_FFFF;
    run_job(0, -1, 0);
    chk("lit3_found", found, 0);
    chk("lit3_nonce", nonce, 0);
    chk("lit3_best", best_hash, 32'hFFFF_FFFF);

    // A hit, then reset during READ, then a normal job
    gen_random(); res[5] = 32'h1; tgt = 32'h100;
    run_job(0, 1, 0);
    gen_random();
    run_job(0, 1, 2);

    // target = 0 and address wrap on header and results
    gen_random(); maddr = 16'hFFF8; tgt = 32'h0;
    run_job(2, 3, 0);
    chk("lit4_found", found, 0);
    gen_random(); maddr = 16'h7FFA;
    run_job(1, -1, 0);

    for (int j = 0; j < 8; j++) begin
      gen_random();
      run_job(int'($urandom_range(0, 2)), int'($urandom_range(0, 6)) - 1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
